// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU slice.
// Holds the multiply/divide unit's op codes, FSM states and latency.
package mips_cpu_pkg;

  localparam int MD_DW      = 32;
  localparam int MD_LATENCY = MD_DW + 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_t;

endpackage

// File: rtl/mips_cpu_divstep.sv
// One restoring-division step.
// Shifts in the next dividend bit and subtracts the divisor if it fits.
module mips_cpu_divstep #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic          q
);

  logic [DW-1:0] trial_lo;
  logic [DW:0]   diff;

  assign trial_lo = {rem[DW-2:0], bit_in};
  assign diff     = {1'b0, trial_lo} - {1'b0, divisor};

  // rem < divisor holds, so a set rem msb means the trial always fits
  assign q        = rem[DW-1] | ~diff[DW];
  assign rem_next = q ? diff[DW-1:0] : trial_lo;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative Hi/Lo multiply/divide unit for MULT/MULTU/DIV/DIVU.
// Magnitude shift-add or restoring divide, then one sign-fix cycle.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  md_op_t        op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(DW);

  md_state_t       state, state_next;
  md_op_t          op_q;
  logic [2*DW-1:0] acc, acc_next, fix;
  logic [DW-1:0]   operand, raw_a;
  logic [DW-1:0]   a_mag, b_mag;
  logic [CW-1:0]   cnt;
  logic            neg_q, neg_r, div0;
  logic            is_signed, is_div, accept;
  logic [DW:0]     sum;
  logic [DW-1:0]   rem_next;
  logic            q_bit;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign accept    = start && !abort && (state == IDLE);

  assign a_mag = (is_signed && a[DW-1]) ? -a : a;
  assign b_mag = (is_signed && b[DW-1]) ? -b : b;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (abort)          state_next = IDLE;
        else if (cnt == '0) state_next = FIX;
      end
      FIX:  state_next = abort ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mips_cpu_divstep #(.DW(DW)) u_divstep (
    .rem      (acc[2*DW-1:DW]),
    .bit_in   (acc[DW-1]),
    .divisor  (operand),
    .rem_next (rem_next),
    .q        (q_bit)
  );

  // Multiply adds into the upper half; the multiplier shifts out LSB first
  assign sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, operand} : '0);

  always_comb begin
    acc_next = {sum, acc[DW-1:1]};
    if (op_q == MD_DIV || op_q == MD_DIVU)
      acc_next = {rem_next, acc[DW-2:0], q_bit};
  end

  always_comb begin
    fix = acc;
    unique case (1'b1)
      (op_q == MD_MULT || op_q == MD_MULTU): begin
        if (neg_q) fix = -acc;
      end
      div0: fix = {raw_a, {DW{1'b1}}};
      default: begin
        if (neg_q) fix[DW-1:0]    = -acc[DW-1:0];
        if (neg_r) fix[2*DW-1:DW] = -acc[2*DW-1:DW];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= MD_MULT;
      acc     <= '0;
      operand <= '0;
      raw_a   <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op;
            raw_a   <= a;
            cnt     <= CW'(DW - 1);
            neg_q   <= is_signed & (a[DW-1] ^ b[DW-1]);
            neg_r   <= is_signed & a[DW-1];
            div0    <= is_div & (b == '0);
            acc     <= {{DW{1'b0}}, is_div ? a_mag : b_mag};
            operand <= is_div ? b_mag : a_mag;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (!abort) begin
            hi <= fix[2*DW-1:DW];
            lo <= fix[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
Iterative multi-cycle multiply/divide unit that produces the Hi/Lo pair for MULT, MULTU, DIV and DIVU. It replaces the single-cycle combinational product/quotient path feeding the ALU's Hi/Lo registers. The datapath writes Hi/Lo from hi/lo on the done pulse. The control unit stalls dependent MFHI/MFLO while busy is high.

Parameters:
DW, 32, operand width; the product is 2*DW, and the iteration count equals DW.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request pulse; sampled only in IDLE
op  in  2  operation (md_op_t): MULT=00, MULTU=01, DIV=10, DIVU=11
a  in  DW  rs operand (multiplicand / dividend)
b  in  DW  rt operand (multiplier / divisor)
abort  in  1  flush (exception/branch squash); cancels the operation in flight
busy  out  1  high whenever state != IDLE
done  out  1  single-cycle pulse when hi/lo hold a new result
hi  out  DW  product[2DW-1:DW] or remainder
lo  out  DW  product[DW-1:0] or quotient

Behaviour:
- Reset (clk is clk; reset rst, synchronous, active-high):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers cleared.
  - rst overrides start and abort, including mid-operation.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - Accept: start=1 in IDLE at cycle t.
  - CALC runs t+1..t+DW; it holds DW iterations driven by a down-counter loaded with DW-1.
  - FIX occurs at t+DW+1.
  - DONE occurs at t+DW+2: done=1 and hi/lo update on that edge, so new values are visible during DONE.
  - The block returns to IDLE at t+DW+3.
  - Fixed latency is MD_LATENCY=DW+2 cycles (34 at DW=32).
- Accept cycle:
  - Latch op.
  - Latch |a| and |b| for signed ops, or raw a and b for unsigned ops.
  - Latch sign flags: neg_q = a[msb]^b[msb] and neg_r = a[msb], both only for signed ops.
  - Latch div0 = (b==0) for divide ops.
  - Changes on a/b/op after accept have no effect.
- start while busy: ignored, with no queuing.
- CALC, multiply: radix-2 shift-add on a 2DW accumulator, one bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. Each cycle computes partial remainder rem' = {rem,dividend_msb} - divisor; if there is no borrow, the quotient bit is 1 and rem' is kept.
- FIX, multiply: if signed and neg_q, negate the full 2DW product (two's complement).
- FIX, divide:
  - Negate the quotient if neg_q.
  - Negate the remainder if neg_r.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 and hi=0. This falls out of the magnitude path; no trap.
- Divide by zero (div0), either signed or unsigned:
  - Sign fix is bypassed.
  - lo=all-ones and hi=a as latched (raw value, not magnitude).
  - Latency is unchanged.
- abort:
  - In CALC or FIX: next state is IDLE, busy drops on the following cycle, no done, hi/lo keep their previous values.
  - In DONE: ignored, because the result is already committed.
  - abort together with start in IDLE: start is ignored.
- Between operations, hi/lo hold their last result indefinitely.

Decomposition:
- Package mips_cpu_pkg holds:
  - md_op_t enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - md_state_t enum: IDLE, CALC, FIX, DONE.
  - Localparam MD_LATENCY.
- One sub-module, mips_cpu_divstep: a combinational single restoring-division step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at t -> done only at t+34, hi=0xFFFFFFFE, lo=0x00000001, busy high t+1..t+34.
2. MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIVU a=7 b=2 -> lo=3, hi=1.
3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5; DIV a=0xFFFFFFFB b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB; done at t+34 in both cases.
5. Start DIVU 100/7, pulse start again at t+5 with different operands, and change a/b mid-op -> a single done at t+34 with lo=14, hi=2; the second start is ignored.
6. Prior result hi=1, lo=3:
   - abort at t+10 -> busy=0 at t+11, no done, hi=1, lo=3 retained.
   - rst at t+10 of a new operation -> hi=lo=0, busy=0 on the next cycle.
